// File: rtl/aes_tiled_round_seq_pkg.sv
// Shared encodings for the tiled AES round sequencer: FSM states, step counter, op one-hots, word selects.
// ST_SUBWORD exists only when AES_TILED_ROUND_SEQ_SUBWORD_EN is defined.
package aes_tiled_round_seq_pkg;

    localparam int WORD_W  = 32;
    localparam int N_WORDS = 4;
    localparam int STEP_W  = 2;

    localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SBSR    = 3'd1;
    localparam logic [2:0] ST_MIX     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
`ifdef AES_TILED_ROUND_SEQ_SUBWORD_EN
    localparam logic [2:0] ST_SUBWORD = 3'd4;
`endif

    // one-hot ordering is {mix, sbsr, sb}
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_SB   = 3'b001;
    localparam logic [2:0] OP_SBSR = 3'b010;
    localparam logic [2:0] OP_MIX  = 3'b100;

    // MIX step k pairs T_k with T_(k^1); SBSR step k reads the column pair {k[1], lo/hi}
    localparam logic [STEP_W-1:0] WSEL_MIX_PARTNER = 2'd1;
    localparam logic              WSEL_LO          = 1'b0;
    localparam logic              WSEL_HI          = 1'b1;

    function automatic logic [STEP_W-1:0] sbsr_word(input logic [STEP_W-1:0] step,
                                                    input logic             half);
        return {step[1], half};
    endfunction

endpackage

// File: rtl/aes_tiled_round_seq.sv
// Sequences one AES round (or a single SubWord) over a 32-bit tiled AES unit via the aes_* handshake.
// Optional SubWord request path enabled by AES_TILED_ROUND_SEQ_SUBWORD_EN; final_round flags the last round.
//
// state   | meaning
// IDLE    | waiting for start (or sw_start)
// SBSR    | four sub-bytes/shift-rows requests, step 0..3
// MIX     | four mix-column requests, step 0..3
// SUBWORD | single sub-bytes request on sw_in
// DONE    | done pulse, state_out valid
module aes_tiled_round_seq
    import aes_tiled_round_seq_pkg::*;
(
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         start,
    input  logic         dec,
    input  logic         final_round,
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
`ifdef AES_TILED_ROUND_SEQ_SUBWORD_EN
    input  logic         sw_start,
    input  logic [31:0]  sw_in,
`endif
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out,
    output logic         aes_valid,
    output logic         aes_dec,
    output logic         aes_op_sb,
    output logic         aes_op_sbsr,
    output logic         aes_op_mix,
    output logic         aes_hi,
    output logic [31:0]  aes_rs1,
    output logic [31:0]  aes_rs2,
    input  logic         aes_ready,
    input  logic [31:0]  aes_rd
);

    logic [2:0]        state_q;
    logic [STEP_W-1:0] step_q;
    logic              dec_q;
    logic              fin_q;
    logic [WORD_W-1:0] r_q [N_WORDS];
    logic [WORD_W-1:0] t_q [N_WORDS];
    logic [WORD_W-1:0] k_q [N_WORDS];
    logic [127:0]      out_q;
    logic [2:0]        op;
    logic              fire;

    // request outputs decode straight from registered state, so they stay put while stalled
    always_comb begin
        aes_valid = 1'b0;
        op        = OP_NONE;
        aes_hi    = 1'b0;
        aes_dec   = 1'b0;
        aes_rs1   = '0;
        aes_rs2   = '0;
        case (state_q)
            ST_SBSR: begin
                aes_valid = 1'b1;
                op        = OP_SBSR;
                aes_hi    = step_q[0];
                aes_dec   = dec_q;
                aes_rs1   = r_q[sbsr_word(step_q, WSEL_LO)];
                aes_rs2   = r_q[sbsr_word(step_q, WSEL_HI)];
            end
            ST_MIX: begin
                aes_valid = 1'b1;
                op        = OP_MIX;
                aes_dec   = dec_q;
                aes_rs1   = t_q[step_q];
                aes_rs2   = t_q[step_q ^ WSEL_MIX_PARTNER];
            end
`ifdef AES_TILED_ROUND_SEQ_SUBWORD_EN
            ST_SUBWORD: begin
                aes_valid = 1'b1;
                op        = OP_SB;
                aes_rs1   = r_q[0];
            end
`endif
            default: ;
        endcase
    end

    assign {aes_op_mix, aes_op_sbsr, aes_op_sb} = op;
    assign fire      = aes_valid && aes_ready;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign state_out = (state_q == ST_DONE) ? {r_q[3], r_q[2], r_q[1], r_q[0]} : out_q;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            dec_q   <= 1'b0;
            fin_q   <= 1'b0;
            out_q   <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                r_q[i] <= '0;
                t_q[i] <= '0;
                k_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    step_q <= '0;
                    if (start) begin
                        dec_q   <= dec;
                        fin_q   <= final_round;
                        for (int i = 0; i < N_WORDS; i++) begin
                            r_q[i] <= state_in[WORD_W*i +: WORD_W];
                            k_q[i] <= rkey[WORD_W*i +: WORD_W];
                        end
                        state_q <= ST_SBSR;
                    end
`ifdef AES_TILED_ROUND_SEQ_SUBWORD_EN
                    else if (sw_start) begin
                        r_q[0]  <= sw_in;
                        state_q <= ST_SUBWORD;
                    end
`endif
                end
                ST_SBSR: if (fire) begin
                    // final rounds stage rd^K in T so the column pairs still read untouched R
                    t_q[step_q] <= (fin_q || dec_q) ? (aes_rd ^ k_q[step_q]) : aes_rd;
                    step_q      <= step_q + 2'd1;
                    if (step_q == LAST_STEP) begin
                        if (fin_q) begin
                            for (int i = 0; i < N_WORDS - 1; i++) r_q[i] <= t_q[i];
                            r_q[N_WORDS-1] <= aes_rd ^ k_q[N_WORDS-1];
                            state_q        <= ST_DONE;
                        end else begin
                            state_q <= ST_MIX;
                        end
                    end
                end
                ST_MIX: if (fire) begin
                    r_q[step_q] <= dec_q ? aes_rd : (aes_rd ^ k_q[step_q]);
                    step_q      <= step_q + 2'd1;
                    if (step_q == LAST_STEP) state_q <= ST_DONE;
                end
`ifdef AES_TILED_ROUND_SEQ_SUBWORD_EN
                ST_SUBWORD: if (fire) begin
                    r_q[0] <= aes_rd;
                    for (int i = 1; i < N_WORDS; i++) r_q[i] <= '0;
                    state_q <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    out_q   <= {r_q[3], r_q[2], r_q[1], r_q[0]};
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
